// File: rtl/fabric_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : fabric_cfg_loader
// Description : Assembles a valid/ready word stream into a shadow register
//               and commits it atomically onto the fabric config bus. The
//               fabric is held in reset until a full image has been committed.
//               Optional checksum word: define CFG_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fabric_cfg_loader #(
  parameter int CFG_WIDTH = 52,
  parameter int WORD_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WORD_W-1:0]    data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [CFG_WIDTH-1:0] config_bits_o,
  output logic                 cfg_valid_o,
  output logic                 busy_o,
  output logic                 fabric_rst_no,
  output logic                 err_o
);

  localparam int c_num_words = (CFG_WIDTH + WORD_W - 1) / WORD_W;
`ifdef CFG_CHECKSUM_EN
  localparam int c_load_words = c_num_words + 1;
`else
  localparam int c_load_words = c_num_words;
`endif
  localparam int                 c_cnt_w = $clog2(c_load_words + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_load_words - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMMIT  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [CFG_WIDTH-1:0] r_shadow;
  logic [CFG_WIDTH-1:0] w_word_sel;
  logic [CFG_WIDTH-1:0] w_word_rep;
  logic                 w_start_load;
  logic                 w_restart;
  logic                 w_xfer;
  logic                 w_last_xfer;
  logic                 w_csum_ok;

  // Bit b of the shadow belongs to word b/WORD_W; bits of the last word beyond
  // CFG_WIDTH simply have no shadow bit, which gives the truncation for free.
  for (genvar b = 0; b < CFG_WIDTH; b++) begin : g_shadow_bit
    assign w_word_rep[b] = data_i[b % WORD_W];
    assign w_word_sel[b] = (r_cnt == c_cnt_w'(b / WORD_W));
  end

  assign w_start_load = (r_state == S_IDLE) && start_i;
  assign w_restart    = (r_state == S_LOAD) && start_i;
  assign w_xfer       = (r_state == S_LOAD) && data_valid_i && !start_i;
  assign w_last_xfer  = w_xfer && (r_cnt == c_last);
  assign data_ready_o = (r_state == S_LOAD);
  assign busy_o       = (r_state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_state_nxt = S_LOAD;
      S_LOAD:    if (w_last_xfer) w_state_nxt = w_csum_ok ? S_COMMIT : S_IDLE;
      S_COMMIT:  w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt         <= '0;
      r_shadow      <= '0;
      config_bits_o <= '0;
      cfg_valid_o   <= 1'b0;
      fabric_rst_no <= 1'b0;
    end else begin
      if (w_start_load || w_restart) begin
        r_cnt    <= '0;
        r_shadow <= '0;
      end else if (w_xfer) begin
        r_cnt    <= r_cnt + 1'b1;
        r_shadow <= (r_shadow & ~w_word_sel) | (w_word_rep & w_word_sel);
      end
      if (w_start_load) begin
        cfg_valid_o   <= 1'b0;
        fabric_rst_no <= 1'b0;
      end
      if (r_state == S_COMMIT) begin
        config_bits_o <= r_shadow;
        cfg_valid_o   <= 1'b1;
      end
      // Release one cycle after commit so the bus is stable before reset drops.
      if (r_state == S_RELEASE) begin
        fabric_rst_no <= 1'b1;
      end
    end
  end

`ifdef CFG_CHECKSUM_EN
  logic [WORD_W-1:0] r_csum;

  assign w_csum_ok = (data_i == r_csum);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_csum <= '0;
      err_o  <= 1'b0;
    end else begin
      if (w_start_load || w_restart) begin
        r_csum <= '0;
      end else if (w_xfer) begin
        r_csum <= r_csum ^ data_i;
      end
      if (w_start_load) begin
        err_o <= 1'b0;
      end else if (w_last_xfer && !w_csum_ok) begin
        err_o <= 1'b1;
      end
    end
  end
`else
  assign w_csum_ok = 1'b1;
  assign err_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fabric_cfg_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fabric_cfg_loader
// Description : Scoreboard bench for fabric_cfg_loader with a word-level
//               reference model; honours CFG_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_cfg_loader;

  localparam int CFG_WIDTH = 52;
  localparam int WORD_W    = 8;
  localparam int NW        = 7;
`ifdef CFG_CHECKSUM_EN
  localparam int LW = NW + 1;
`else
  localparam int LW = NW;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b1;
  logic                 valid = 1'b1;
  logic [WORD_W-1:0]    data = 8'hA5;
  logic                 data_ready;
  logic [CFG_WIDTH-1:0] config_bits;
  logic                 cfg_valid;
  logic                 busy;
  logic                 fabric_rst_n;
  logic                 err;

  fabric_cfg_loader #(.CFG_WIDTH(CFG_WIDTH), .WORD_W(WORD_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .data_i        (data),
    .data_valid_i  (valid),
    .data_ready_o  (data_ready),
    .config_bits_o (config_bits),
    .cfg_valid_o   (cfg_valid),
    .busy_o        (busy),
    .fabric_rst_no (fabric_rst_n),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  // Reference model: words collected so far, and what the outputs should be.
  bit             m_loading = 1'b0;
  bit             m_valid   = 1'b0;
  bit             m_rstn    = 1'b0;
  bit             m_err     = 1'b0;
  int             m_done    = 0;
  bit [51:0]      m_image   = '0;
  bit [7:0]       m_words[$];

  typedef struct {
    bit [51:0] img;
    int        cyc;
  } exp_t;
  exp_t sb_q[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  function automatic bit [51:0] pack_words();
    bit [55:0] t;
    t = '0;
    for (int k = 0; k < NW; k++) t[k*8 +: 8] = m_words[k];
    return t[51:0];
  endfunction

  function automatic bit [7:0] xor_words();
    bit [7:0] x;
    x = '0;
    for (int k = 0; k < NW; k++) x ^= m_words[k];
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit ok;
    if (rst) begin
      m_loading = 1'b0; m_words.delete(); m_done = 0;
      m_image = '0; m_valid = 1'b0; m_rstn = 1'b0; m_err = 1'b0;
    end else if (m_done == 2) begin
      m_image = pack_words(); m_valid = 1'b1; m_done = 1;
    end else if (m_done == 1) begin
      m_rstn = 1'b1; m_done = 0;
    end else if (!m_loading) begin
      if (start) begin
        m_loading = 1'b1; m_words.delete();
        m_valid = 1'b0; m_rstn = 1'b0; m_err = 1'b0;
      end
    end else if (start) begin
      m_words.delete();
    end else if (valid) begin
      m_words.push_back(data);
      if (m_words.size() == LW) begin
        m_loading = 1'b0;
`ifdef CFG_CHECKSUM_EN
        ok = (m_words[NW] == xor_words());
`else
        ok = 1'b1;
`endif
        if (ok) begin
          m_done = 2;
          sb_q.push_back('{pack_words(), cyc + 1});
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    valid = 1'b1; data = d; tick(); valid = 1'b0;
  endtask

  // Monitor: per-cycle output check plus scoreboard pop on each commit.
  initial begin
    bit prev_v;
    bit rstn_due;
    exp_t e;
    prev_v   = 1'b0;
    rstn_due = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("config_bits", 64'(config_bits), 64'(m_image));
        chk("cfg_valid", 64'(cfg_valid), 64'(m_valid));
        chk("fabric_rst_n", 64'(fabric_rst_n), 64'(m_rstn));
        chk("busy", 64'(busy), 64'(m_loading || m_done != 0));
        chk("data_ready", 64'(data_ready), 64'(m_loading));
        chk("err", 64'(err), 64'(m_err));
        if (cfg_valid && !prev_v) begin
          chk("sb_pending", 64'(sb_q.size() != 0), 64'(1));
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_image", 64'(config_bits), 64'(e.img));
            chk("sb_latency", 64'(cyc), 64'(e.cyc));
            chk("sb_rstn_held", 64'(fabric_rst_n), 64'(0));
            rstn_due = 1'b1;
          end
        end else if (rstn_due) begin
          chk("sb_rstn_rise", 64'(fabric_rst_n), 64'(1));
          chk("sb_image_stable", 64'(config_bits), 64'(m_image));
          rstn_due = 1'b0;
        end
        prev_v = cfg_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    // Reset with start and valid held high
    repeat (2) tick();
    rst = 1'b0; start = 1'b0; valid = 1'b0;
    tick();

    // Back-to-back load of 0x01..0x07
    pulse_start();
    for (int i = 1; i <= NW; i++) send(8'(i));
`ifdef CFG_CHECKSUM_EN
    send(8'h00);
`endif
    repeat (4) tick();

    // Valid high in IDLE, then toggled valid during load
    valid = 1'b1; data = 8'h33;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= LW; i++) begin
      valid = 1'b0; tick();
      valid = 1'b1; data = (i > NW) ? 8'h00 : 8'(i); tick();
    end
    valid = 1'b0;
    repeat (4) tick();

    // Restart mid-load, then reset mid-load
    pulse_start();
    repeat (3) send(8'hAA);
    pulse_start();
    repeat (NW) send(8'hFF);
`ifdef CFG_CHECKSUM_EN
    send(xor_words());
`endif
    repeat (4) tick();
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'(8'hC3 + i));
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (3) tick();

    // Reload over a valid image; start pulsed during COMMIT
    pulse_start();
    for (int i = 1; i <= NW; i++) send(8'(i));
`ifdef CFG_CHECKSUM_EN
    send(8'h00);
`endif
    repeat (4) tick();
    pulse_start();
    for (int i = 0; i < NW; i++) send(8'(8'h10 + i));
`ifdef CFG_CHECKSUM_EN
    send(xor_words());
`endif
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();

`ifdef CFG_CHECKSUM_EN
    // Good checksum, bad checksum, then start clears err
    pulse_start();
    for (int i = 1; i <= NW; i++) send(8'(i));
    send(8'h00);
    repeat (4) tick();
    pulse_start();
    for (int i = 1; i <= NW; i++) send(8'(i));
    send(8'h5A);
    repeat (4) tick();
    pulse_start();
    repeat (2) tick();
`endif

    // Randomized loads
    repeat (30) begin
      start = 1'b1; valid = 1'($urandom_range(0, 1)); data = 8'($urandom);
      tick();
      start = 1'b0;
      budget = 0;
      while (m_loading && budget < 200) begin
        budget++;
        start = ($urandom_range(0, 19) == 0);
        valid = ($urandom_range(0, 2) != 0);
        data  = 8'($urandom);
`ifdef CFG_CHECKSUM_EN
        if (m_words.size() == NW && $urandom_range(0, 3) != 0) data = xor_words();
`endif
        if ($urandom_range(0, 99) == 0) begin
          rst = 1'b1; tick(); rst = 1'b0;
          break;
        end
        tick();
      end
      start = 1'b0; valid = 1'b0;
      repeat ($urandom_range(2, 5)) begin
        start = ($urandom_range(0, 3) == 0);
        valid = 1'($urandom_range(0, 1));
        data  = 8'($urandom);
        tick();
      end
      start = 1'b0; valid = 1'b0;
    end

    repeat (6) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fabric_cfg_loader.md
Name: fabric_cfg_loader

Overview:
Upstream configuration stage for fabric_2x2. Accepts configuration data as a valid/ready word stream and assembles it into a shadow register. It then commits the whole image atomically onto the fabric's config bus. It holds the fabric in reset while loading and releases the reset only after a complete image has been committed.

Parameters:
CFG_WIDTH, 52, total configuration bits driven to the fabric (4 CLBs x 13 bits).
WORD_W, 8, width of one input data word.
NUM_WORDS, derived as ceil(CFG_WIDTH/WORD_W) (7 at defaults); not user-overridable.

Ports:
clk_i  input  1  clock; all logic on the rising edge.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  one-cycle pulse; begins or restarts a load.
data_i  input  WORD_W  configuration word.
data_valid_i  input  1  data_i valid.
data_ready_o  output  1  loader can accept a word.
config_bits_o  output  CFG_WIDTH  active configuration; drives fabric config_bits.
cfg_valid_o  output  1  config_bits_o holds a committed image.
busy_o  output  1  high in any state other than IDLE.
fabric_rst_no  output  1  active-low reset to the fabric; drives fabric rst_n.
err_o  output  1  checksum failure flag; tied 0 unless CFG_CHECKSUM_EN.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high on rst_i.
- Reset (rst_i=1 at an edge) places the block in this state; rst_i has priority over everything, including mid-load:
  - state=IDLE, word count 0, shadow 0.
  - config_bits_o=0, cfg_valid_o=0, busy_o=0, data_ready_o=0, fabric_rst_no=0, err_o=0.
- States: IDLE, LOAD, COMMIT, RELEASE.
- IDLE:
  - data_ready_o=0; no word is accepted even if data_valid_i=1.
  - start_i=1 -> LOAD next cycle; clears count, shadow and err_o, sets cfg_valid_o=0 and fabric_rst_no=0.
  - config_bits_o keeps its old value until the next commit.
- LOAD:
  - data_ready_o=1. A transfer occurs when data_valid_i&data_ready_o at an edge.
  - Word k (0-based) is written to shadow[k*WORD_W +: WORD_W].
  - The last word is truncated; its bits above CFG_WIDTH are ignored.
  - On the NUM_WORDS-th transfer -> COMMIT. data_ready_o is 0 from the next cycle.
  - start_i during LOAD restarts the load: count=0, shadow=0, stay in LOAD. If start_i and a transfer coincide, the restart wins and the word is dropped.
- COMMIT (1 cycle): config_bits_o<=shadow, cfg_valid_o<=1 -> RELEASE.
- RELEASE (1 cycle): fabric_rst_no<=1 -> IDLE.
- start_i is ignored in COMMIT and RELEASE.
- Latency, with the last transfer at edge of cycle T:
  - COMMIT during T+1.
  - config_bits_o and cfg_valid_o valid from T+2.
  - fabric_rst_no high from T+3.
  - The config bus is therefore stable at least one cycle before the fabric leaves reset.
- fabric_rst_no is 0 whenever cfg_valid_o=0.
- config_bits_o never changes except at COMMIT or rst_i.

Optional Feature:
CFG_CHECKSUM_EN
- Defined:
  - LOAD accepts NUM_WORDS+1 words; the extra word is a checksum.
  - Checksum = bitwise XOR of all NUM_WORDS full data words, including padding bits.
  - Match -> COMMIT as normal.
  - Mismatch -> err_o<=1 and return to IDLE. config_bits_o is unchanged, cfg_valid_o stays 0 and fabric_rst_no stays 0.
  - err_o is cleared by the next start_i or by rst_i.
- Undefined: exactly NUM_WORDS words per load; err_o is constant 0.

Test Plan:
1. Assert rst_i for 2 cycles, with start_i=1 and data_valid_i=1 held -> all outputs 0, state IDLE, data_ready_o=0.
2. Pulse start_i, then stream 0x01..0x07 back-to-back -> config_bits_o=52'h7_0605_0403_0201. cfg_valid_o rises at T+2, fabric_rst_no at T+3. data_ready_o=0 after the 7th word.
3. Same load with data_valid_i toggled every other cycle and data_valid_i=1 in IDLE before start_i -> identical image; exactly 7 transfers counted.
4. Start and send 0xAA x3, then pulse start_i, then send 0xFF x7 -> config_bits_o=52'hF_FFFF_FFFF_FFFF. Then repeat the load and assert rst_i after 4 words -> all outputs 0, no commit.
5. After a valid image, pulse start_i:
   - cfg_valid_o=0 and fabric_rst_no=0 on the next cycle.
   - config_bits_o holds the old image until the new commit.
   - start_i pulsed during COMMIT is ignored.
6. (CFG_CHECKSUM_EN) Send 0x01..0x07:
   - With checksum 0x00 -> commit, err_o=0.
   - With checksum 0x5A -> err_o=1, no commit, fabric_rst_no=0.
   - A following start_i clears err_o.
